fft_frame_collector: RTL and testbench
======================================

// Module: fft_frame_collector
// PURPOSE
//   Serial-to-parallel input stage feeding the 4-point FFT butterfly stage.
//   Collects four consecutive signed 16-bit Q8.8 filter samples, converts each to a 32-bit Q16.16 real
//   value, and sets every imaginary part to zero. It then presents one complete frame in natural order
//   (x0..x3) under a valid/ready handshake.
//   Double-buffered: collection of the next frame continues while the current frame waits downstream.
// PARAMETERS
//   IN_W    16  input sample width, signed Q8.8
//   OUT_W   32  output word width, signed Q16.16
// PORTS
//   clk           input   1      rising-edge clock
//   rst           input   1      synchronous, active-high reset
//   in_valid      input   1      in_data valid this cycle; no backpressure on input side
//   in_data       input   16     signed Q8.8 sample
//   frame_ready   input   1      downstream accepts frame when high with frame_valid
//   frame_valid   output  1      frame_x*_real/imag hold a complete frame
//   frame_x0_real output  32     sample 0 (oldest), Q16.16; x1..x3 same, in arrival order
//   frame_x1_real output  32
//   frame_x2_real output  32
//   frame_x3_real output  32
//   frame_x0_imag output  32     constant 32'h0 (likewise x1..x3_imag)
//   frame_x1_imag output  32
//   frame_x2_imag output  32
//   frame_x3_imag output  32
//   overrun       output  1      sticky: a completed frame was dropped; cleared only by rst
//   frame_count   output  8      number of frames accepted downstream, wraps 255->0
// BEHAVIOUR
//   Reset (rst sampled high at clk edge): all outputs 0, fill counter 0, collect buffer cleared.
//   Conversion: out = {{8{d[15]}}, d, 8'h00}. Exact and lossless, e.g. 16'h0100 (+1.0) -> 32'h00010000.
//   Collect: on each in_valid, write the converted word to collect slot[fill] and set fill <= fill+1 (mod 4).
//   Completion: the in_valid cycle with fill==3 completes a frame.
//   - Output buffer free (frame_valid==0, or frame_valid&&frame_ready this same cycle):
//     copy slots 0..2 plus the completing sample into the output registers.
//     frame_valid=1 from the next cycle. Latency: last sample edge -> frame_valid high one cycle later.
//   - Output buffer occupied and not being accepted this cycle: drop the completed frame, set overrun=1.
//     Output registers stay untouched; fill still wraps to 0.
//   Handshake: frame_valid&&frame_ready at an edge means accepted.
//   - frame_valid drops next cycle unless a new frame loads at that same edge, in which case it stays 1.
//   - frame_count increments on every acceptance.
//   - Output data must stay stable while frame_valid=1 and not accepted.
//   in_valid low: nothing changes; gaps of any length between samples are legal.
//   rst mid-frame: partial frame discarded, fill=0; the next sample becomes x0.
//   Imag outputs are driven constant 0; no registers are needed for them.
// STRUCTURE
//   Shared package fft_pkg holds:
//   - localparams FFT_POINTS=4, Q_FRAC=16, IN_FRAC=8
//   - the Q8.8->Q16.16 conversion function
//   - twiddle constants W0 = 32'h00010000 + j0 and W1 = 0 - j1 (imag 32'hFFFF0000)
//   Control (2-bit fill counter, frame_valid, overrun, frame_count) is one always block.
//   No sub-module; both the collect buffer and the output buffer are plain register arrays.
// TESTING
//   1 Reset, then in_valid with 16'h0100,16'h0200,16'hFF00,16'h0000 on consecutive cycles, frame_ready=1.
//     -> frame_valid high exactly 1 cycle, one cycle after the 4th sample.
//     -> x0..x3_real = 32'h00010000,32'h00020000,32'hFFFF0000,32'h00000000; all imag 0.
//     -> frame_count=1.
//   2 Same 4 samples, each separated by 3 idle cycles. -> identical frame; frame_valid only after the 4th sample.
//   3 frame_ready=0. Send 4 samples, then 4 more.
//     -> first frame held stable, second frame dropped, overrun=1.
//     -> Raise frame_ready: first frame accepted, frame_valid=0, frame_count=1.
//   4 Back-to-back 8 samples with frame_ready=1 at the 4th-sample edge of frame 2.
//     -> frame_valid stays 1 across the swap; outputs switch to frame 2 with no gap and no overrun.
//   5 Send 2 samples, pulse rst, send 4 samples 16'h0010..16'h0013.
//     -> frame x0 = 32'h00001000 (from 16'h0010), no residue of the pre-reset samples; overrun=0.
//   6 Stream 256 frames with frame_ready=1. -> frame_count wraps to 0; overrun stays 0.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared definitions for the 4-point FFT datapath.
// Includes fixed-point formats, the Q8.8 to Q16.16 input conversion, and the twiddle constants.
package fft_pkg;

  localparam int FFT_POINTS = 4;
  localparam int Q_FRAC     = 16;
  localparam int IN_FRAC    = 8;

  // Twiddles in Q16.16: W0 = 1 + j0, W1 = 0 - j1
  localparam logic [31:0] W0_REAL = 32'h0001_0000;
  localparam logic [31:0] W0_IMAG = 32'h0000_0000;
  localparam logic [31:0] W1_REAL = 32'h0000_0000;
  localparam logic [31:0] W1_IMAG = 32'hFFFF_0000;

  typedef logic [1:0] fill_t;

  // The conversion is lossless. It sign-extends the integer part and pads the fraction from 8 to 16 bits.
  function automatic logic [31:0] q88_to_q1616(input logic [15:0] d);
    return {{8{d[15]}}, d, 8'h00};
  endfunction

endpackage

// File: rtl/fft_frame_collector.sv
// Collects four Q8.8 samples into a Q16.16 frame (imag = 0) and presents it under valid/ready.
// Collection buffer and output buffer are independent, so the next frame fills while one waits.
module fft_frame_collector
  import fft_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_data,
  input  logic             frame_ready,
  output logic             frame_valid,
  output logic [OUT_W-1:0] frame_x0_real,
  output logic [OUT_W-1:0] frame_x1_real,
  output logic [OUT_W-1:0] frame_x2_real,
  output logic [OUT_W-1:0] frame_x3_real,
  output logic [OUT_W-1:0] frame_x0_imag,
  output logic [OUT_W-1:0] frame_x1_imag,
  output logic [OUT_W-1:0] frame_x2_imag,
  output logic [OUT_W-1:0] frame_x3_imag,
  output logic             overrun,
  output logic [7:0]       frame_count
);

  fill_t            fill;
  logic [OUT_W-1:0] collect_buf [0:FFT_POINTS-2];
  logic [OUT_W-1:0] out_buf     [0:FFT_POINTS-1];
  logic [OUT_W-1:0] in_word;
  logic             accept;
  logic             complete;
  logic             load;

  assign in_word  = q88_to_q1616(in_data);
  assign accept   = frame_valid && frame_ready;
  assign complete = in_valid && (fill == 2'd3);
  // The output buffer counts as free if it is empty or being accepted at this same edge.
  assign load     = complete && (!frame_valid || frame_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      fill        <= 2'd0;
      frame_valid <= 1'b0;
      overrun     <= 1'b0;
      frame_count <= 8'd0;
    end else begin
      if (in_valid)
        fill <= fill + 2'd1;
      if (load)
        frame_valid <= 1'b1;
      else if (accept)
        frame_valid <= 1'b0;
      if (complete && !load)
        overrun <= 1'b1;
      if (accept)
        frame_count <= frame_count + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FFT_POINTS - 1; i++)
        collect_buf[i] <= '0;
      for (int i = 0; i < FFT_POINTS; i++)
        out_buf[i] <= '0;
    end else begin
      if (in_valid) begin
        case (fill)
          2'd0:    collect_buf[0] <= in_word;
          2'd1:    collect_buf[1] <= in_word;
          2'd2:    collect_buf[2] <= in_word;
          default: ;
        endcase
      end
      // The completing sample goes straight to x3, so the collect buffer needs only three slots.
      if (load) begin
        out_buf[0] <= collect_buf[0];
        out_buf[1] <= collect_buf[1];
        out_buf[2] <= collect_buf[2];
        out_buf[3] <= in_word;
      end
    end
  end

  assign frame_x0_real = out_buf[0];
  assign frame_x1_real = out_buf[1];
  assign frame_x2_real = out_buf[2];
  assign frame_x3_real = out_buf[3];
  assign frame_x0_imag = '0;
  assign frame_x1_imag = '0;
  assign frame_x2_imag = '0;
  assign frame_x3_imag = '0;

endmodule

// File: tb/tb_fft_frame_collector.sv
// Directed bench for fft_frame_collector.
// A behavioural model pushes expected frames to a scoreboard, and each frame is popped when the DUT hands it off.
module tb_fft_frame_collector;

  typedef struct packed {
    logic [31:0] x0;
    logic [31:0] x1;
    logic [31:0] x2;
    logic [31:0] x3;
  } frame_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_data;
  logic        frame_ready;
  logic        frame_valid;
  logic [31:0] frame_x0_real, frame_x1_real, frame_x2_real, frame_x3_real;
  logic [31:0] frame_x0_imag, frame_x1_imag, frame_x2_imag, frame_x3_imag;
  logic        overrun;
  logic [7:0]  frame_count;

  int vectors;
  int miscompares;

  frame_t      exp_q[$];
  int          m_fill;
  logic [31:0] m_slot [3];
  logic        m_valid;
  logic        m_overrun;
  logic [7:0]  m_count;

  fft_frame_collector dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .frame_ready   (frame_ready),
    .frame_valid   (frame_valid),
    .frame_x0_real (frame_x0_real),
    .frame_x1_real (frame_x1_real),
    .frame_x2_real (frame_x2_real),
    .frame_x3_real (frame_x3_real),
    .frame_x0_imag (frame_x0_imag),
    .frame_x1_imag (frame_x1_imag),
    .frame_x2_imag (frame_x2_imag),
    .frame_x3_imag (frame_x3_imag),
    .overrun       (overrun),
    .frame_count   (frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Q8.8 to Q16.16 is a scale by 256 of the sign-extended value.
  function automatic logic [31:0] to_q16(input logic [15:0] d);
    logic [31:0] ext;
    ext = {{16{d[15]}}, d};
    return ext << 8;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    m_fill = 0;
    m_valid = 1'b0;
    m_overrun = 1'b0;
    m_count = 8'd0;
    exp_q.delete();
  endtask

  // One clock cycle: check the current outputs against the model, update the model, then clock the DUT.
  task automatic applyStimulus(input logic v, input logic [15:0] d, input logic rdy);
    logic acc;
    frame_t f;
    checkOutput("frame_valid", {31'd0, frame_valid}, {31'd0, m_valid});
    checkOutput("overrun", {31'd0, overrun}, {31'd0, m_overrun});
    checkOutput("frame_count", {24'd0, frame_count}, {24'd0, m_count});
    if (m_valid && exp_q.size() > 0) begin
      checkOutput("x0_real", frame_x0_real, exp_q[0].x0);
      checkOutput("x1_real", frame_x1_real, exp_q[0].x1);
      checkOutput("x2_real", frame_x2_real, exp_q[0].x2);
      checkOutput("x3_real", frame_x3_real, exp_q[0].x3);
    end
    checkOutput("imag_or", frame_x0_imag | frame_x1_imag | frame_x2_imag | frame_x3_imag, 32'h0);

    acc = m_valid && rdy;
    if (acc) begin
      void'(exp_q.pop_front());
      m_count = m_count + 8'd1;
      m_valid = 1'b0;
    end
    if (v) begin
      if (m_fill == 3) begin
        if (m_valid) begin
          m_overrun = 1'b1;
        end else begin
          f = '{x0: m_slot[0], x1: m_slot[1], x2: m_slot[2], x3: to_q16(d)};
          exp_q.push_back(f);
          m_valid = 1'b1;
        end
        m_fill = 0;
      end else begin
        m_slot[m_fill] = to_q16(d);
        m_fill = m_fill + 1;
      end
    end

    in_valid = v;
    in_data = d;
    frame_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    in_valid = 1'b0;
    frame_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    modelReset();
  endtask

  initial begin
    logic [15:0] s1 [4];
    vectors = 0;
    miscompares = 0;
    rst = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    frame_ready = 1'b0;
    s1 = '{16'h0100, 16'h0200, 16'hFF00, 16'h0000};

    doReset();
    checkOutput("rst_valid", {31'd0, frame_valid}, 32'd0);
    checkOutput("rst_x0", frame_x0_real, 32'h0);
    checkOutput("rst_x3", frame_x3_real, 32'h0);
    checkOutput("rst_count", {24'd0, frame_count}, 32'd0);
    checkOutput("rst_overrun", {31'd0, overrun}, 32'd0);

    $display("[TB] test 1: consecutive samples");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, s1[i], 1'b1);
      checkOutput("t1_no_early_valid", {31'd0, frame_valid}, 32'd0);
    end
    applyStimulus(1'b1, s1[3], 1'b1);
    checkOutput("t1_valid", {31'd0, frame_valid}, 32'd1);
    checkOutput("t1_x0", frame_x0_real, 32'h0001_0000);
    checkOutput("t1_x1", frame_x1_real, 32'h0002_0000);
    checkOutput("t1_x2", frame_x2_real, 32'hFFFF_0000);
    checkOutput("t1_x3", frame_x3_real, 32'h0000_0000);
    applyStimulus(1'b0, 16'h0, 1'b1);
    checkOutput("t1_valid_drop", {31'd0, frame_valid}, 32'd0);
    checkOutput("t1_count", {24'd0, frame_count}, 32'd1);

    $display("[TB] test 2: gapped samples");
    for (int i = 0; i < 4; i++) begin
      checkOutput("t2_no_early_valid", {31'd0, frame_valid}, 32'd0);
      applyStimulus(1'b1, s1[i], 1'b1);
      if (i < 3)
        for (int g = 0; g < 3; g++) applyStimulus(1'b0, 16'h0, 1'b1);
    end
    checkOutput("t2_valid", {31'd0, frame_valid}, 32'd1);
    checkOutput("t2_x2", frame_x2_real, 32'hFFFF_0000);
    applyStimulus(1'b0, 16'h0, 1'b1);
    checkOutput("t2_count", {24'd0, frame_count}, 32'd2);

    $display("[TB] test 3: backpressure and overrun");
    doReset();
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, s1[i], 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 16'h7F00 + 16'(i), 1'b0);
    checkOutput("t3_overrun", {31'd0, overrun}, 32'd1);
    checkOutput("t3_held_x0", frame_x0_real, 32'h0001_0000);
    checkOutput("t3_held_x3", frame_x3_real, 32'h0000_0000);
    applyStimulus(1'b0, 16'h0, 1'b1);
    checkOutput("t3_valid_drop", {31'd0, frame_valid}, 32'd0);
    checkOutput("t3_count", {24'd0, frame_count}, 32'd1);
    checkOutput("t3_overrun_sticky", {31'd0, overrun}, 32'd1);

    $display("[TB] test 4: swap without gap");
    doReset();
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, s1[i], 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 16'h0A00 + 16'(i), 1'b0);
    applyStimulus(1'b1, 16'h8000, 1'b1);
    checkOutput("t4_valid_stays", {31'd0, frame_valid}, 32'd1);
    checkOutput("t4_x0", frame_x0_real, 32'h000A_0000);
    checkOutput("t4_x3", frame_x3_real, 32'hFF80_0000);
    checkOutput("t4_no_overrun", {31'd0, overrun}, 32'd0);
    checkOutput("t4_count", {24'd0, frame_count}, 32'd1);
    applyStimulus(1'b0, 16'h0, 1'b1);

    $display("[TB] test 5: reset mid-frame");
    applyStimulus(1'b1, 16'h5555, 1'b1);
    applyStimulus(1'b1, 16'h6666, 1'b1);
    doReset();
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 16'h0010 + 16'(i), 1'b0);
    checkOutput("t5_valid", {31'd0, frame_valid}, 32'd1);
    checkOutput("t5_x0", frame_x0_real, 32'h0000_1000);
    checkOutput("t5_x3", frame_x3_real, 32'h0000_1300);
    checkOutput("t5_overrun", {31'd0, overrun}, 32'd0);
    applyStimulus(1'b0, 16'h0, 1'b1);

    $display("[TB] test 6: frame_count wrap");
    doReset();
    for (int f = 0; f < 256; f++)
      for (int i = 0; i < 4; i++)
        applyStimulus(1'b1, 16'(($urandom_range(0, 65535))), 1'b1);
    applyStimulus(1'b0, 16'h0, 1'b1);
    checkOutput("t6_count_wrap", {24'd0, frame_count}, 32'd0);
    checkOutput("t6_no_overrun", {31'd0, overrun}, 32'd0);
    checkOutput("t6_idle", {31'd0, frame_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
